// File: rtl/eco32f_div_pkg.sv
// Shared constants for the eco32f serial divider scheduler.
package eco32f_div_pkg;

  // FSM state encodings (kept as plain constants for older tools)
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // Owner encodings: EX pipeline stage and the secondary client
  localparam logic DIV_PORT_EX  = 1'b0;
  localparam logic DIV_PORT_AUX = 1'b1;

endpackage

// File: rtl/eco32f_div_step.sv
// One radix-2 restoring divide iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not go negative.
module eco32f_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] n_nxt
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // Trial subtract. The shifted remainder is carried in WIDTH+1 bits so the compare
  // stays exact even when the partial remainder MSB is set (divisor above 2^(WIDTH-1)).
  // The kept difference is always below d, so a WIDTH-bit subtract is enough for it.
  always_comb begin
    shifted = {r, n[WIDTH-1]};
    fits    = (shifted >= {1'b0, d});
    r_nxt   = fits ? (shifted[WIDTH-1:0] - d) : shifted[WIDTH-1:0];
    n_nxt   = {n[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/eco32f_div_sched.sv
// Shared serial-divider scheduler: round-robin between the EX port (0) and an
// auxiliary port (1), one quotient bit per cycle, one-cycle response pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DIV_IDLE | waiting for a request; both ready (port 0 not while flush0)
//   DIV_RUN  | WIDTH restoring iterations in progress
//   DIV_DONE | result presented for one cycle to the owning port
module eco32f_div_sched
  import eco32f_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_signed,
  input  logic             req0_rem,
  input  logic             flush0,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_signed,
  input  logic             req1_rem,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_div_by_zero,
  output logic             busy
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             rem_q;
  logic             neg_q;
  logic             dz_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] d_q;

  logic             is_idle;
  logic             is_run;
  logic             is_done;
  logic             acc0;
  logic             acc1;
  logic             grant;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic             sel_signed;
  logic             sel_rem;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic             flush_own;
  logic [WIDTH-1:0] res_mag;
  logic [WIDTH-1:0] res_fix;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] n_nxt;

  eco32f_div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r_q),
    .n     (n_q),
    .d     (d_q),
    .r_nxt (r_nxt),
    .n_nxt (n_nxt)
  );

  // Handshake, round-robin arbitration and operand magnitude conversion
  always_comb begin
    is_idle    = (state == DIV_IDLE);
    is_run     = (state == DIV_RUN);
    is_done    = (state == DIV_DONE);
    req0_ready = is_idle && !flush0;
    req1_ready = is_idle;
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    // on a tie the port that did not win last time goes first
    grant      = (acc0 && acc1) ? ~last_grant : acc1;
    sel_x      = grant ? req1_x      : req0_x;
    sel_y      = grant ? req1_y      : req0_y;
    sel_signed = grant ? req1_signed : req0_signed;
    sel_rem    = grant ? req1_rem    : req0_rem;
    x_mag      = (sel_signed && sel_x[WIDTH-1]) ? -sel_x : sel_x;
    y_mag      = (sel_signed && sel_y[WIDTH-1]) ? -sel_y : sel_y;
    flush_own  = flush0 && (owner == DIV_PORT_EX) && (is_run || is_done);
  end

  // Response formatting; outputs are zero except in DONE
  always_comb begin
    res_mag          = rem_q ? r_q : n_q;
    res_fix          = neg_q ? -res_mag : res_mag;
    resp0_valid      = is_done && (owner == DIV_PORT_EX) && !flush0;
    resp1_valid      = is_done && (owner == DIV_PORT_AUX);
    resp_result      = is_done ? res_fix : '0;
    resp_div_by_zero = is_done && dz_q;
    busy             = !is_idle;
  end

  // Sequencer: accept, iterate WIDTH times, present result, return to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      owner      <= DIV_PORT_EX;
      last_grant <= DIV_PORT_AUX;
      rem_q      <= 1'b0;
      neg_q      <= 1'b0;
      dz_q       <= 1'b0;
      r_q        <= '0;
      n_q        <= '0;
      d_q        <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (acc0 || acc1) begin
            owner      <= grant;
            last_grant <= grant;
            rem_q      <= sel_rem;
            neg_q      <= sel_signed &
                          (sel_rem ? sel_x[WIDTH-1] : (sel_x[WIDTH-1] ^ sel_y[WIDTH-1]));
            dz_q       <= (sel_y == '0);
            cnt        <= CNT_W'(WIDTH);
            r_q        <= '0;
            n_q        <= x_mag;
            d_q        <= y_mag;
            state      <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (flush_own) begin
            state <= DIV_IDLE;
          end else begin
            r_q <= r_nxt;
            n_q <= n_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= DIV_DONE;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eco32f_div_sched.sv
// Bench for eco32f_div_sched: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_eco32f_div_sched;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 0, req0_signed = 0, req0_rem = 0, flush0 = 0;
  logic [W-1:0]  req0_x = '0, req0_y = '0;
  logic          req1_valid = 0, req1_signed = 0, req1_rem = 0;
  logic [W-1:0]  req1_x = '0, req1_y = '0;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid, resp_div_by_zero, busy;
  logic [W-1:0]  resp_result;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  eco32f_div_sched #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_signed(req0_signed), .req0_rem(req0_rem), .flush0(flush0),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_signed(req1_signed), .req1_rem(req1_rem),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_result(resp_result), .resp_div_by_zero(resp_div_by_zero), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic rem);
    logic [W-1:0] ax, ay, q, r, res;
    logic neg;
    ax = (s && x[W-1]) ? -x : x;
    ay = (s && y[W-1]) ? -y : y;
    if (ay == '0) begin
      q = '1;
      r = ax;
    end else begin
      q = ax / ay;
      r = ax % ay;
    end
    neg = s && (rem ? x[W-1] : (x[W-1] ^ y[W-1]));
    res = rem ? r : q;
    return neg ? -res : res;
  endfunction

  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t         m_ph;
  logic         m_owner, m_last, m_dz;
  logic [W-1:0] m_res;
  longint       cyc, m_t_done;

  logic m_a0, m_a1, m_gp;
  assign m_a0 = req0_valid && !flush0;
  assign m_a1 = req1_valid;
  assign m_gp = (m_a0 && m_a1) ? ~m_last : m_a1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph     <= M_IDLE;
      m_owner  <= 1'b0;
      m_last   <= 1'b1;
      m_dz     <= 1'b0;
      m_res    <= '0;
      cyc      <= 0;
      m_t_done <= 0;
    end else begin
      cyc <= cyc + 1;
      case (m_ph)
        M_IDLE: if (m_a0 || m_a1) begin
          m_ph     <= M_RUN;
          m_owner  <= m_gp;
          m_last   <= m_gp;
          m_t_done <= cyc + W;
          m_res    <= m_gp ? ref_div(req1_x, req1_y, req1_signed, req1_rem)
                           : ref_div(req0_x, req0_y, req0_signed, req0_rem);
          m_dz     <= m_gp ? (req1_y == '0) : (req0_y == '0);
        end
        M_RUN: begin
          if (!m_owner && flush0) m_ph <= M_IDLE;
          else if (cyc == m_t_done) m_ph <= M_DONE;
        end
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  logic [37:0] exp_vec, act_vec;
  assign exp_vec = {m_ph == M_IDLE && !flush0, m_ph == M_IDLE, m_ph != M_IDLE,
                    m_ph == M_DONE && !m_owner && !flush0, m_ph == M_DONE && m_owner,
                    m_ph == M_DONE && m_dz, (m_ph == M_DONE) ? m_res : 32'h0};
  assign act_vec = {req0_ready, req1_ready, busy, resp0_valid, resp1_valid,
                    resp_div_by_zero, resp_result};

  always @(negedge clk) begin
    if (chk_en && !rst) check("cycle_model", 64'(act_vec), 64'(exp_vec));
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input int port, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic rem, input logic [W-1:0] exp_res,
                        input logic exp_dz, input string name);
    int k, lat;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_x = x; req0_y = y; req0_signed = s; req0_rem = rem; req0_valid = 1'b1;
    end else begin
      req1_x = x; req1_y = y; req1_signed = s; req1_rem = rem; req1_valid = 1'b1;
    end
    k = 0;
    while (!(port == 0 ? req0_ready : req1_ready) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check({name, "_accept_in_time"}, 64'(k < 100), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!(port == 0 ? resp0_valid : resp1_valid) && lat < 100);
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_result"}, 64'(resp_result), 64'(exp_res));
    check({name, "_dz"}, 64'(resp_div_by_zero), 64'(exp_dz));
  endtask

  initial begin
    int got[4];
    int ng, lat, k;
    logic seen0;

    #22;
    check("reset_outputs", 64'({busy, resp0_valid, resp1_valid, resp_div_by_zero, resp_result}), 64'd0);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;
    #1 check("ready_after_reset", 64'({req0_ready, req1_ready}), 64'b11);

    run_op(0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0, "u_div");
    run_op(0, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0, "u_rem");
    run_op(0, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 32'hFFFFFFF2, 1'b0, "s_div");
    run_op(0, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, "s_rem");
    run_op(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b0, "s_ovf_div");
    run_op(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 1'b0, "s_ovf_rem");
    run_op(0, 32'h1234, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, "dz_div");
    run_op(0, 32'h1234, 32'h0, 1'b0, 1'b1, 32'h1234, 1'b1, "dz_rem");
    run_op(1, 32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 1'b0, "p1_div");
    run_op(1, 32'd100, 32'hFFFFFFF9, 1'b1, 1'b0, 32'hFFFFFFF2, 1'b0, "p1_sdiv");
    run_op(1, 32'd100, 32'hFFFFFFF9, 1'b1, 1'b1, 32'd2, 1'b0, "p1_srem");

    // both ports held valid from reset: grants alternate starting with port 0
    @(posedge clk); #1 rst = 1'b1;
    req0_x = 32'd100; req0_y = 32'd7;  req0_signed = 0; req0_rem = 0; req0_valid = 1'b1;
    req1_x = 32'd50;  req1_y = 32'd5;  req1_signed = 0; req1_rem = 0; req1_valid = 1'b1;
    @(negedge clk); rst = 1'b0;
    ng = 0; k = 0;
    while (ng < 4 && k < 400) begin
      @(negedge clk); k++;
      if (resp0_valid || resp1_valid) begin
        got[ng] = resp1_valid ? 1 : 0;
        check("tie_result", 64'(resp_result), resp1_valid ? 64'd10 : 64'd14);
        ng++;
      end
    end
    check("tie_resp_count", 64'(ng), 64'd4);
    check("tie_order", 64'({got[0][0], got[1][0], got[2][0], got[3][0]}), 64'b0101);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    // flush of port-0 work with port 1 waiting
    #1;
    req0_x = 32'd1000; req0_y = 32'd3; req0_valid = 1'b1;
    check("flush_p0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_x = 32'd77; req1_y = 32'd7; req1_signed = 0; req1_rem = 0; req1_valid = 1'b1;
    repeat (9) @(posedge clk);
    #1 flush0 = 1'b1;
    check("flush_p1_blocked", 64'(req1_ready), 64'd0);
    @(posedge clk); #1 flush0 = 1'b0;
    check("flush_back_idle", 64'({busy, req1_ready}), 64'b01);
    @(posedge clk); #1;
    check("flush_p1_accepted", 64'(busy), 64'd1);
    req1_valid = 1'b0;
    lat = 0; seen0 = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (resp0_valid) seen0 = 1'b1;
    end while (!resp1_valid && lat < 100);
    check("flush_p1_latency", 64'(lat), 64'd33);
    check("flush_p1_result", 64'(resp_result), 64'd11);
    check("flush_no_resp0", 64'(seen0), 64'd0);

    // asynchronous reset in the middle of a run
    @(posedge clk); #1;
    req0_x = 32'd100; req0_y = 32'd7; req0_signed = 0; req0_rem = 0; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset_outs",
             64'({busy, resp0_valid, resp1_valid, resp_div_by_zero, resp_result}), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(0, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, "post_reset");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
